// File: rtl/chunked_seq_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds CHUNK bits per clock with the carry
// held in a register, operands and result exchanged over valid/ready handshakes.
module chunked_seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IW-1:0]    r_idx;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Operands shift right each BUSY cycle, so the active chunk is always the low bits.
    assign w_a_chunk = r_a[CHUNK-1:0];
    assign w_b_chunk = r_b[CHUNK-1:0];
    assign {w_c, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_idx == LastIdx);

    // Result chunks enter from the top; after N shifts chunk 0 sits at the bottom.
    if (CHUNK == WIDTH) begin : g_single
        assign w_sum_next = w_s;
    end else begin : g_multi
        assign w_sum_next = {w_s, r_sum[WIDTH-1:CHUNK]};
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (in_valid)  w_state_d = StBusy;
            StBusy:  if (w_last)    w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = StIdle;
            default:                w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                    end
                end
                StBusy: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_sum   <= w_sum_next;
                    r_carry <= w_c;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_c;
                        r_ovf  <= (w_a_chunk[CHUNK-1] == w_b_chunk[CHUNK-1]) &&
                                  (w_s[CHUNK-1] != w_a_chunk[CHUNK-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: directed table vectors and corner sequences on 16/4,
// plus random operations on four WIDTH/CHUNK configurations against an arithmetic model.
module tb_chunked_seq_adder;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        in_valid;
    logic [3:0]        out_ready;
    logic [31:0]       a_in   [4];
    logic [31:0]       b_in   [4];
    logic [3:0]        cin_in;
    logic [3:0]        sub_in;
    logic [3:0]        in_ready_o;
    logic [3:0]        out_valid_o;
    logic [3:0]        cout_o;
    logic [3:0]        ovf_o;
    logic [3:0][31:0]  sum_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Config 0: 16/1, 1: 16/4, 2: 16/16, 3: 32/8
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned W = (g == 3) ? 32 : 16;
        localparam int unsigned C = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 8;
        logic [W-1:0] w_sum;
        chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready_o[g]),
            .a         (a_in[g][W-1:0]),
            .b         (b_in[g][W-1:0]),
            .cin       (cin_in[g]),
            .sub       (sub_in[g]),
            .out_valid (out_valid_o[g]),
            .out_ready (out_ready[g]),
            .sum       (w_sum),
            .cout      (cout_o[g]),
            .overflow  (ovf_o[g])
        );
        assign sum_o[g] = 32'(w_sum);
    end

    function automatic int w_of(int k);
        return (k == 3) ? 32 : 16;
    endfunction

    function automatic int n_of(int k);
        case (k)
            0:       return 16;
            1:       return 4;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed values.
    task automatic model(input int w, input longint a, input longint b, input bit cin,
                         input bit sub, output longint s, output bit co, output bit ov);
        longint full = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint u, sa, sb, sv;
        u  = sub ? (a - b + full) : (a + b + longint'(cin));
        s  = u & (full - 1);
        co = (u >= full);
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        sv = sub ? (sa - sb) : (sa + sb + longint'(cin));
        ov = (sv >= half) || (sv < -half);
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input int k, input longint a, input longint b, input bit cin,
                        input bit sub);
        @(negedge clk);
        a_in[k]     = 32'(a);
        b_in[k]     = 32'(b);
        cin_in[k]   = cin;
        sub_in[k]   = sub;
        in_valid[k] = 1'b1;
        check($sformatf("k%0d in_ready before accept", k), longint'(in_ready_o[k]), 1);
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            #1 cyc++;
            if (out_valid_o[k]) break;
            if (cyc >= 64) begin
                check($sformatf("k%0d out_valid timeout", k), 0, 1);
                break;
            end
        end
    endtask

    task automatic check_result(input int k, input longint s, input bit co, input bit ov);
        check($sformatf("k%0d sum", k), longint'(sum_o[k]), s);
        check($sformatf("k%0d cout", k), longint'(cout_o[k]), longint'(co));
        check($sformatf("k%0d overflow", k), longint'(ovf_o[k]), longint'(ov));
    endtask

    task automatic drain(input int k);
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1 out_ready[k] = 1'b0;
        check($sformatf("k%0d in_ready after drain", k), longint'(in_ready_o[k]), 1);
        check($sformatf("k%0d out_valid after drain", k), longint'(out_valid_o[k]), 0);
    endtask

    task automatic run_op(input int k, input longint a, input longint b, input bit cin,
                          input bit sub, input longint s, input bit co, input bit ov);
        int lat;
        send(k, a, b, cin, sub);
        wait_done(k, lat);
        check($sformatf("k%0d latency", k), longint'(lat), longint'(n_of(k)));
        check_result(k, s, co, ov);
        drain(k);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    initial begin
        vec_t   vecs[5];
        int     lat;
        longint ra, rb, rs;
        bit     rc, rsub, rco, rov;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        in_valid  = '0;
        out_ready = '0;
        cin_in    = '0;
        sub_in    = '0;
        for (int k = 0; k < 4; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end

        // Reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #2;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("k%0d reset in_ready", k), longint'(in_ready_o[k]), 1);
            check($sformatf("k%0d reset out_valid", k), longint'(out_valid_o[k]), 0);
            check_result(k, 0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(1, longint'(vecs[i].a), longint'(vecs[i].b), vecs[i].cin, vecs[i].sub,
                   longint'(vecs[i].sum), vecs[i].cout, vecs[i].ovf);
        end

        // Backpressure, with a stray in_valid pulse during BUSY.
        send(1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        a_in[1]     = 32'h0F0F;
        b_in[1]     = 32'h0F0F;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        check("bp in_ready busy", longint'(in_ready_o[1]), 0);
        wait_done(1, lat);
        check("bp latency", longint'(lat + 1), 4);
        for (int i = 0; i < 5; i++) begin
            check_result(1, 16'h5555, 1'b0, 1'b0);
            check("bp in_ready done", longint'(in_ready_o[1]), 0);
            check("bp out_valid held", longint'(out_valid_o[1]), 1);
            @(posedge clk);
            #1;
        end
        drain(1);
        repeat (3) begin
            @(posedge clk);
            #1 check("no second op", longint'(out_valid_o[1]), 0);
        end

        // Reset during the second BUSY cycle.
        send(1, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst in_ready", longint'(in_ready_o[1]), 1);
        check("midrst out_valid", longint'(out_valid_o[1]), 0);
        check("midrst sum", longint'(sum_o[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random sweep over all configurations.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 1000; i++) begin
                longint m = (longint'(1) << w_of(k)) - 1;
                ra   = longint'($urandom) & m;
                rb   = longint'($urandom) & m;
                rc   = 1'($urandom);
                rsub = 1'($urandom);
                model(w_of(k), ra, rb, rc, rsub, rs, rco, rov);
                run_op(k, ra, rb, rc, rsub, rs, rco, rov);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
